// File: rtl/fsm_command_pkg.sv
// fsm_command_pkg -- shared definitions for the command FSM slice.
//   state_t              : FSM state encoding (IDLE, TRANSIT)
//   CMD_GO / CMD_STOP    : command opcodes carried in cmd[7:6]
//   BUZZ_HALF_CNT_DEF    : default buzzer half-period in clk cycles
//                          (4 kHz tone at 50 MHz)
package fsm_command_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    TRANSIT = 1'b1
  } state_t;

  localparam logic [1:0] CMD_GO   = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b00;

  localparam int unsigned BUZZ_HALF_CNT_DEF = 6250;

endpackage

// File: rtl/fsm_command_piezo_drv.sv
// piezo_drv -- square-wave piezo driver.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   en     : tone enable; while low the counter holds at 0 and buzz is 0
//   buzz   : piezo drive, toggles every BUZZ_HALF_CNT clks while enabled
//   buzz_n : complement of buzz
module piezo_drv
  import fsm_command_pkg::*;
#(
  parameter int unsigned BUZZ_HALF_CNT = BUZZ_HALF_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam int unsigned CW = (BUZZ_HALF_CNT > 1) ? $clog2(BUZZ_HALF_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_HALF_CNT - 1);

  logic [CW-1:0] cnt;
  logic          buzz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      buzz_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      buzz_q <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      buzz_q <= ~buzz_q;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Gate with en so the drive drops the same cycle the tone is disabled,
  // rather than one edge later when buzz_q clears.
  assign buzz   = buzz_q & en;
  assign buzz_n = ~buzz;

endmodule

// File: rtl/fsm_command.sv
// fsm_command -- robot command FSM: decodes UART command bytes (GO/STOP),
// tracks the destination station and stops on arrival at a matching
// barcode ID. Optional piezo buzzer sounds while blocked in transit.
// Build option: define FSM_CMD_BUZZER_EN to include the piezo_drv buzzer;
// otherwise buzz=0 and buzz_n=1 with no counter logic.
//   clk, rst      : clock, asynchronous active-high reset
//   cmd, cmd_rdy  : command byte and its pending flag (UART receiver)
//   ID, ID_vld    : station ID and its pending flag (barcode reader)
//   OK2Move       : path ahead is clear
//   clr_cmd_rdy   : one-cycle pulse consuming cmd
//   clr_ID_vld    : one-cycle pulse consuming ID
//   in_transit    : high in TRANSIT
//   go            : motion enable (in_transit & OK2Move)
//   buzz, buzz_n  : complementary piezo drive
module fsm_command
  import fsm_command_pkg::*;
#(
  parameter int unsigned BUZZ_HALF_CNT = BUZZ_HALF_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  input  logic       OK2Move,
  output logic       clr_cmd_rdy,
  output logic       clr_ID_vld,
  output logic       in_transit,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n
);

  if (BUZZ_HALF_CNT == 0) begin : g_bad_half_cnt
    $error("BUZZ_HALF_CNT must be nonzero");
  end

  state_t     state;
  logic [5:0] dest_ID;

  // A pending command always wins; an ID is only consumed when no command
  // is pending, so it stays queued behind the command.
  always_comb begin
    clr_cmd_rdy = cmd_rdy;
    clr_ID_vld  = ID_vld & ~cmd_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dest_ID <= '0;
    end else if (cmd_rdy) begin
      case (cmd[7:6])
        CMD_GO: begin
          dest_ID <= cmd[5:0];
          state   <= TRANSIT;
        end
        CMD_STOP: state <= IDLE;
        default:  ;
      endcase
    end else if (ID_vld && (state == TRANSIT) &&
                 (ID[7:6] == 2'b00) && (ID[5:0] == dest_ID)) begin
      state <= IDLE;
    end
  end

  assign in_transit = (state == TRANSIT);
  assign go         = in_transit & OK2Move;

`ifdef FSM_CMD_BUZZER_EN
  logic buzz_en;
  assign buzz_en = in_transit & ~OK2Move;

  piezo_drv #(
    .BUZZ_HALF_CNT(BUZZ_HALF_CNT)
  ) u_piezo (
    .clk   (clk),
    .rst   (rst),
    .en    (buzz_en),
    .buzz  (buzz),
    .buzz_n(buzz_n)
  );
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b1;
`endif

endmodule

// File: tb/tb_fsm_command.sv
module tb_fsm_command;

  localparam int unsigned HALF = 4;
`ifdef FSM_CMD_BUZZER_EN
  localparam bit BZ_EN = 1'b1;
`else
  localparam bit BZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       OK2Move;
  logic       clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n;

  int tests = 0;
  int fails = 0;

  fsm_command #(.BUZZ_HALF_CNT(HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .OK2Move    (OK2Move),
    .clr_cmd_rdy(clr_cmd_rdy),
    .clr_ID_vld (clr_ID_vld),
    .in_transit (in_transit),
    .go         (go),
    .buzz       (buzz),
    .buzz_n     (buzz_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART receiver model: byte presented with cmd_rdy, held until the
  // consuming edge, then the flag drops. Checks the combinational clear.
  task automatic send_cmd(input logic [7:0] c, input string tag);
    @(negedge clk);
    cmd = c; cmd_rdy = 1'b1;
    #1 chk({tag, "_clr_cmd"}, {7'd0, clr_cmd_rdy}, 8'd1);
    @(posedge clk);
    #1 cmd_rdy = 1'b0;
    #1 chk({tag, "_clr_cmd_low"}, {7'd0, clr_cmd_rdy}, 8'd0);
  endtask

  // Barcode source model, same handshake on ID_vld / clr_ID_vld.
  task automatic send_id(input logic [7:0] v, input string tag);
    @(negedge clk);
    ID = v; ID_vld = 1'b1;
    #1 chk({tag, "_clr_id"}, {7'd0, clr_ID_vld}, 8'd1);
    @(posedge clk);
    #1 ID_vld = 1'b0;
    #1 chk({tag, "_clr_id_low"}, {7'd0, clr_ID_vld}, 8'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_transit"}, {7'd0, in_transit}, 8'd0);
    chk({tag, "_go"},         {7'd0, go},         8'd0);
    chk({tag, "_buzz"},       {7'd0, buzz},       8'd0);
    chk({tag, "_buzz_n"},     {7'd0, buzz_n},     8'd1);
    chk({tag, "_clr_cmd"},    {7'd0, clr_cmd_rdy}, 8'd0);
    chk({tag, "_clr_id"},     {7'd0, clr_ID_vld},  8'd0);
  endtask

  initial begin
    rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; ID = '0; ID_vld = 1'b0; OK2Move = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("reset");
    chk("reset_dest", {2'b00, dut.dest_ID}, 8'h00);
    @(negedge clk) rst = 1'b0;

    // GO to station 4
    send_cmd(8'h44, "go44");
    chk("go44_transit", {7'd0, in_transit}, 8'd1);
    chk("go44_go", {7'd0, go}, 8'd1);
    chk("go44_dest", {2'b00, dut.dest_ID}, 8'h04);

    // STOP
    send_cmd(8'h04, "stop");
    chk("stop_transit", {7'd0, in_transit}, 8'd0);
    chk("stop_go", {7'd0, go}, 8'd0);

    // Wrong station then right one
    send_cmd(8'h44, "go44b");
    send_id(8'h07, "id07");
    chk("id07_transit", {7'd0, in_transit}, 8'd1);
    send_id(8'h04, "id04");
    chk("id04_transit", {7'd0, in_transit}, 8'd0);

    // Nonzero upper bits never match
    send_cmd(8'h46, "go46");
    send_id(8'hC4, "idC4");
    chk("idC4_transit", {7'd0, in_transit}, 8'd1);
    send_id(8'h84, "id84");
    chk("id84_transit", {7'd0, in_transit}, 8'd1);
    send_id(8'h44, "id44");
    chk("id44_transit", {7'd0, in_transit}, 8'd1);
    send_id(8'h06, "id06");
    chk("id06_transit", {7'd0, in_transit}, 8'd0);

    // ID in IDLE is discarded
    send_id(8'h06, "idle_id");
    chk("idle_id_transit", {7'd0, in_transit}, 8'd0);

    // Ignored code in IDLE
    send_cmd(8'h84, "ign_idle");
    chk("ign_idle_transit", {7'd0, in_transit}, 8'd0);

    // cmd and ID together: cmd first, ID left pending
    @(negedge clk);
    cmd = 8'h45; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
    #1 chk("both_clr_cmd", {7'd0, clr_cmd_rdy}, 8'd1);
    chk("both_clr_id", {7'd0, clr_ID_vld}, 8'd0);
    @(posedge clk);
    #1 cmd_rdy = 1'b0;
    #1 chk("both_transit", {7'd0, in_transit}, 8'd1);
    chk("both_id_pending", {7'd0, clr_ID_vld}, 8'd1);
    @(posedge clk);
    #1 ID_vld = 1'b0;
    #1 chk("both_arrive", {7'd0, in_transit}, 8'd0);

    // Ignored code in TRANSIT
    send_cmd(8'h4F, "go4F");
    send_cmd(8'hC0, "ign_tr");
    chk("ign_tr_transit", {7'd0, in_transit}, 8'd1);

    // GO overwrites destination while travelling
    send_cmd(8'h4A, "go4A");
    chk("go4A_dest", {2'b00, dut.dest_ID}, 8'h0A);
    send_cmd(8'h4F, "go4F_b");
    chk("go4F_dest", {2'b00, dut.dest_ID}, 8'h0F);

    // Blocked: buzzer toggles every HALF clks
    @(negedge clk) OK2Move = 1'b0;
    #1 chk("blk_go", {7'd0, go}, 8'd0);
    repeat (HALF - 1) @(posedge clk);
    #1 chk("bz_pre", {7'd0, buzz}, 8'd0);
    @(posedge clk);
    #1 chk("bz_t1", {7'd0, buzz}, {7'd0, BZ_EN});
    chk("bzn_t1", {7'd0, buzz_n}, {7'd0, ~BZ_EN});
    repeat (HALF - 1) @(posedge clk);
    #1 chk("bz_hold", {7'd0, buzz}, {7'd0, BZ_EN});
    @(posedge clk);
    #1 chk("bz_t2", {7'd0, buzz}, 8'd0);
    chk("bzn_t2", {7'd0, buzz_n}, 8'd1);
    repeat (HALF) @(posedge clk);
    #1 chk("bz_t3", {7'd0, buzz}, {7'd0, BZ_EN});
    @(negedge clk) OK2Move = 1'b1;
    #1 chk("clear_go", {7'd0, go}, 8'd1);
    chk("clear_buzz", {7'd0, buzz}, 8'd0);
    chk("clear_buzz_n", {7'd0, buzz_n}, 8'd1);

    // Async reset mid-transit
    @(negedge clk) OK2Move = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outs("mid_rst");
    chk("mid_rst_dest", {2'b00, dut.dest_ID}, 8'h00);
    @(negedge clk) rst = 1'b0; OK2Move = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", {7'd0, in_transit}, 8'd0);
    send_id(8'h0F, "post_rst_id");
    chk("post_rst_id_idle", {7'd0, in_transit}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
